pwm_gen: RTL and testbench

PWM_GEN -- requirements
Module: pwm_gen

---
 rtl/pwm_pkg.sv | 25 ++
 rtl/pwm_channel.sv | 48 ++++
 rtl/pwm_gen.sv | 165 ++++++++++++++++
 tb/tb_pwm_gen.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg
//   Shared constants for the PWM generator: register map, default widths and
//   a helper that places the ENABLE register directly after the last DUTY
//   register for any channel count.
// ---------------------------------------------------------------------------
package pwm_pkg;

    localparam int CNT_W_DEFAULT    = 16;
    localparam int CHANNELS_DEFAULT = 4;
    localparam int ADDR_W           = 4;

    localparam logic [ADDR_W-1:0] ADDR_PERIOD    = 4'd0;
    localparam logic [ADDR_W-1:0] ADDR_DUTY_BASE = 4'd1;

    // ENABLE sits one past the last DUTY register, so its address depends on
    // how many channels the instance has.
    function automatic logic [ADDR_W-1:0] enableAddr(input int channels);
        return ADDR_DUTY_BASE + ADDR_W'(channels);
    endfunction

    // ENABLE address for the default channel count.
    localparam logic [ADDR_W-1:0] ADDR_ENABLE = enableAddr(CHANNELS_DEFAULT);

endpackage

// File: rtl/pwm_channel.sv
// ---------------------------------------------------------------------------
// pwm_channel
//   One PWM output: a registered compare of the shared period counter
//   against this channel's active duty value.
//
//   Ports
//     clk       : clock, rising edge
//     rst       : synchronous active-high reset
//     run_i     : counter is running (active period is nonzero)
//     enable_i  : active enable bit for this channel
//     cnt_i     : shared period counter
//     duty_i    : active duty value for this channel
//     pwm_o     : registered PWM waveform
// ---------------------------------------------------------------------------
module pwm_channel #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_i,
    input  logic             enable_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic [CNT_W-1:0] duty_i,
    output logic             pwm_o
);

    logic pwm_q;
    logic pwm_d;

    // Because the counter never passes period-1, a duty of period or more
    // keeps the compare true on every count, so the output stays high across
    // the wrap without any special case; duty 0 never compares true.
    always_comb begin
        pwm_d = run_i && enable_i && (cnt_i < duty_i);
    end

    // Output register: one cycle of latency from the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_gen.sv
// ---------------------------------------------------------------------------
// pwm_gen
//   Multi-channel PWM generator with a shared period counter and
//   double-buffered (staging / active) PERIOD, DUTY and ENABLE registers.
//   Writes land in staging and are committed to the active set at the
//   counter wrap, so a waveform never changes mid-period. While the counter
//   is stopped (active period 0) a pending write commits on the next edge.
//
//   Ports
//     clk         : clock, rising edge
//     rst         : synchronous active-high reset
//     wr_en       : single-cycle register write strobe
//     wr_addr     : register address (0 PERIOD, 1..CHANNELS DUTY, CHANNELS+1 ENABLE)
//     wr_data     : write data
//     wr_err      : one-cycle pulse after a write to an unmapped address
//     pwm_out     : PWM waveforms, one per channel
//     period_tick : one-cycle pulse in the cycle after each counter wrap
// ---------------------------------------------------------------------------
module pwm_gen
    import pwm_pkg::*;
#(
    parameter int CHANNELS = CHANNELS_DEFAULT,
    parameter int CNT_W    = CNT_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [CNT_W-1:0]    wr_data,
    output logic                wr_err,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_tick
);

    localparam logic [ADDR_W-1:0] ENABLE_ADDR = enableAddr(CHANNELS);
    localparam logic [CNT_W-1:0]  ONE         = CNT_W'(1);

    logic [CNT_W-1:0]                cnt_q,       cnt_d;
    logic [CNT_W-1:0]                periodStg_q, periodStg_d;
    logic [CNT_W-1:0]                periodAct_q, periodAct_d;
    logic [CHANNELS-1:0][CNT_W-1:0]  dutyStg_q,   dutyStg_d;
    logic [CHANNELS-1:0][CNT_W-1:0]  dutyAct_q,   dutyAct_d;
    logic [CHANNELS-1:0]             enableStg_q, enableStg_d;
    logic [CHANNELS-1:0]             enableAct_q, enableAct_d;
    logic                            pending_q,   pending_d;
    logic                            wrErr_q,     wrErr_d;
    logic                            tick_q,      tick_d;

    logic                periodHit;
    logic                enableHit;
    logic [CHANNELS-1:0] dutyHit;
    logic                mapped;
    logic                running;
    logic                wrap;
    logic                commit;

    // Address decode: one hit line per register.
    always_comb begin
        periodHit = (wr_addr == ADDR_PERIOD);
        enableHit = (wr_addr == ENABLE_ADDR);
        dutyHit   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            dutyHit[i] = (wr_addr == ADDR_DUTY_BASE + ADDR_W'(i));
        end
        mapped = periodHit || enableHit || (|dutyHit);
    end

    // A wrap is the edge leaving cnt == period-1. A stopped counter commits
    // any pending write on the very next edge so it can be restarted. The
    // commit copies the staging values as they stood before this edge, so a
    // write landing on the commit edge is not part of it.
    always_comb begin
        running = (periodAct_q != '0);
        wrap    = running && (cnt_q == periodAct_q - ONE);
        commit  = pending_q && (wrap || !running);
    end

    // Next-state for counter, staging/active register file and pulses.
    always_comb begin
        cnt_d       = '0;
        periodStg_d = periodStg_q;
        dutyStg_d   = dutyStg_q;
        enableStg_d = enableStg_q;
        periodAct_d = periodAct_q;
        dutyAct_d   = dutyAct_q;
        enableAct_d = enableAct_q;
        pending_d   = pending_q;
        tick_d      = wrap;
        wrErr_d     = wr_en && !mapped;

        if (running && !wrap) begin
            cnt_d = cnt_q + ONE;
        end

        if (commit) begin
            periodAct_d = periodStg_q;
            dutyAct_d   = dutyStg_q;
            enableAct_d = enableStg_q;
            pending_d   = 1'b0;
        end

        // A new write re-arms pending even on a commit edge, so it waits
        // for the following wrap.
        if (wr_en && mapped) begin
            pending_d = 1'b1;
            if (periodHit) begin
                periodStg_d = wr_data;
            end
            if (enableHit) begin
                enableStg_d = wr_data[CHANNELS-1:0];
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (dutyHit[i]) begin
                    dutyStg_d[i] = wr_data;
                end
            end
        end
    end

    // State registers; reset discards the running period and any pending
    // write, and takes priority over a simultaneous write strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            periodStg_q <= '0;
            periodAct_q <= '0;
            dutyStg_q   <= '0;
            dutyAct_q   <= '0;
            enableStg_q <= '0;
            enableAct_q <= '0;
            pending_q   <= 1'b0;
            wrErr_q     <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            periodStg_q <= periodStg_d;
            periodAct_q <= periodAct_d;
            dutyStg_q   <= dutyStg_d;
            dutyAct_q   <= dutyAct_d;
            enableStg_q <= enableStg_d;
            enableAct_q <= enableAct_d;
            pending_q   <= pending_d;
            wrErr_q     <= wrErr_d;
            tick_q      <= tick_d;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        pwm_channel #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .run_i    (running),
            .enable_i (enableAct_q[g]),
            .cnt_i    (cnt_q),
            .duty_i   (dutyAct_q[g]),
            .pwm_o    (pwm_out[g])
        );
    end

    assign wr_err      = wrErr_q;
    assign period_tick = tick_q;

endmodule

// File: tb/tb_pwm_gen.sv
// ---------------------------------------------------------------------------
// tb_pwm_gen
//   Directed bench for pwm_gen (4 channels, 16-bit counter). A main run
//   follows a fixed write schedule; expected outputs come from a small
//   schedule-based model indexed by edge number after the first commit.
// ---------------------------------------------------------------------------
module tb_pwm_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wr_err;
    logic [3:0]  pwm_out;
    logic        period_tick;

    int totalChecks = 0;
    int badChecks   = 0;

    pwm_gen #(
        .CHANNELS (4),
        .CNT_W    (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_err      (wr_err),
        .pwm_out     (pwm_out),
        .period_tick (period_tick)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // One rising edge, then park on the falling edge for sampling/driving.
    task automatic stepClock();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One register write, captured on the next rising edge.
    task automatic applyStimulus(input logic [3:0] addr, input logic [15:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        stepClock();
        wr_en   = 1'b0;
    endtask

    // Model of the committed configuration as a function of state index j
    // (state after edge C+j, C being the first commit edge):
    //   j <  80 : PERIOD 10 running, cnt = j % 10
    //   80..85  : PERIOD 0, stopped
    //   j >= 86 : PERIOD 6 running, cnt = (j-86) % 6
    //   DUTY0 is 3 until the wrap at 30, 8 until the wrap at 60, then 5.
    function automatic bit runOf(input int j);
        return (j >= 0 && j < 80) || (j >= 86);
    endfunction

    function automatic int periodOf(input int j);
        return (j < 80) ? 10 : 6;
    endfunction

    function automatic int cntOf(input int j);
        if (j < 0)   return 0;
        if (j < 80)  return j % 10;
        if (j >= 86) return (j - 86) % 6;
        return 0;
    endfunction

    function automatic int dutyOf(input int ch, input int j);
        case (ch)
            0:       return (j < 30) ? 3 : ((j < 60) ? 8 : 5);
            1:       return 0;
            2:       return 10;
            default: return 4;
        endcase
    endfunction

    // Outputs after edge C+k reflect the state after edge C+k-1.
    function automatic logic [3:0] pwmExp(input int k);
        logic [3:0] e;
        e = '0;
        for (int ch = 0; ch < 4; ch++) begin
            e[ch] = runOf(k - 1) && (cntOf(k - 1) < dutyOf(ch, k - 1));
        end
        return e;
    endfunction

    function automatic logic tickExp(input int k);
        return runOf(k - 1) && (cntOf(k - 1) == periodOf(k - 1) - 1);
    endfunction

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;

        // Reset state
        @(negedge clk);
        stepClock();
        stepClock();
        checkOutput("reset pwm",  32'(pwm_out),     32'h0);
        checkOutput("reset tick", 32'(period_tick), 32'h0);
        checkOutput("reset err",  32'(wr_err),      32'h0);
        rst = 1'b0;
        stepClock();
        checkOutput("idle pwm",  32'(pwm_out),     32'h0);
        checkOutput("idle tick", 32'(period_tick), 32'h0);

        // Configure while stopped; PERIOD written last
        applyStimulus(4'd1, 16'd3);
        checkOutput("setup duty0 pwm", 32'(pwm_out), 32'h0);
        applyStimulus(4'd2, 16'd0);
        applyStimulus(4'd3, 16'd10);
        applyStimulus(4'd4, 16'd4);
        applyStimulus(4'd5, 16'h000F);
        checkOutput("setup enable pwm", 32'(pwm_out), 32'h0);
        applyStimulus(4'd0, 16'd10);
        checkOutput("setup period pwm",  32'(pwm_out),     32'h0);
        checkOutput("setup period tick", 32'(period_tick), 32'h0);

        // Main run: basic PWM, duty boundaries, shadow update, write on the
        // wrap edge, unmapped writes, stop and restart
        for (int k = 0; k <= 97; k++) begin
            case (k)
                25:      applyStimulus(4'd1,  16'd8);
                50:      applyStimulus(4'd1,  16'd5);
                62:      applyStimulus(4'd15, 16'h0001);
                64:      applyStimulus(4'd6,  16'h0001);
                72:      applyStimulus(4'd0,  16'd0);
                85:      applyStimulus(4'd0,  16'd6);
                95:      applyStimulus(4'd1,  16'd2);
                default: stepClock();
            endcase
            checkOutput($sformatf("pwm k=%0d", k),  32'(pwm_out),     32'(pwmExp(k)));
            checkOutput($sformatf("tick k=%0d", k), 32'(period_tick), 32'(tickExp(k)));
            checkOutput($sformatf("err k=%0d", k),  32'(wr_err),
                        32'((k == 62) || (k == 64)));
        end

        // Reset at cnt=5 with a pending DUTY0 write; writes during reset
        // must be ignored
        rst     = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 4'd0;
        wr_data = 16'd3;
        stepClock();
        checkOutput("rst1 pwm",  32'(pwm_out),     32'h0);
        checkOutput("rst1 tick", 32'(period_tick), 32'h0);
        checkOutput("rst1 err",  32'(wr_err),      32'h0);
        wr_addr = 4'd15;
        stepClock();
        checkOutput("rst2 pwm", 32'(pwm_out), 32'h0);
        checkOutput("rst2 err", 32'(wr_err),  32'h0);
        rst   = 1'b0;
        wr_en = 1'b0;

        for (int i = 0; i < 8; i++) begin
            stepClock();
            checkOutput($sformatf("post-rst pwm i=%0d", i),  32'(pwm_out),     32'h0);
            checkOutput($sformatf("post-rst tick i=%0d", i), 32'(period_tick), 32'h0);
        end

        // Only PERIOD=4 written: staging was cleared, so the counter runs
        // but every channel stays disabled
        applyStimulus(4'd0, 16'd4);
        checkOutput("restart tick i=0", 32'(period_tick), 32'h0);
        for (int i = 1; i <= 7; i++) begin
            stepClock();
            checkOutput($sformatf("restart tick i=%0d", i), 32'(period_tick), 32'(i == 5));
            checkOutput($sformatf("restart pwm i=%0d", i),  32'(pwm_out),     32'h0);
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
